// File: rtl/cei_mochila_pkg.sv
// Platform constants for the peripheral subsystem: master count and the
// index type used to tag in-flight transactions with their issuing master.
package cei_mochila_pkg;

  localparam int unsigned NUM_PERIPH_MASTERS = 2;

  // Wide enough for up to 8 masters.
  localparam int unsigned PERIPH_MST_IDX_W = 3;

  typedef logic [PERIPH_MST_IDX_W-1:0] periph_mst_idx_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by masters, arbiter and slave port.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/periph_obi_arbiter_if.sv
// Bundle of the arbiter's bus-side signals; arb modport faces the arbiter,
// env modport faces the masters/slave model driving it.
interface periph_obi_arbiter_if
  import obi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
);

  obi_req_t  master_req  [NUM_MASTERS];
  obi_resp_t master_resp [NUM_MASTERS];
  obi_req_t  slave_req;
  obi_resp_t slave_resp;
  logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding;

  modport arb (
    input  master_req, slave_resp,
    output master_resp, slave_req, outstanding
  );

  modport env (
    output master_req, slave_resp,
    input  master_resp, slave_req, outstanding
  );

endinterface

// File: rtl/periph_arb_id_fifo.sv
// In-order FIFO of master indices for granted transactions; the head names
// the master that owns the next rvalid. Push when full / pop when empty are
// ignored.
module periph_arb_id_fifo
  import cei_mochila_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH+1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  periph_mst_idx_t data_i,
  input  logic            pop_i,
  output periph_mst_idx_t data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CNT_W-1:0] count_o
);

  periph_mst_idx_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state pointers wrap at DEPTH (which need not be a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every in-flight tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage needs no reset: validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/periph_obi_arbiter.sv
// N:1 OBI arbiter in front of the peripheral-system slave port. Zero-latency
// combinational grant and rvalid steering; an ID FIFO remembers the issuing
// master of each outstanding transaction so responses return in order.
// Build option: define PERIPH_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer); default is round-robin.
module periph_obi_arbiter
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = NUM_PERIPH_MASTERS,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  obi_req_t         master_req_i  [NUM_MASTERS],
  output obi_resp_t        master_resp_o [NUM_MASTERS],
  output obi_req_t         slave_req_o,
  input  obi_resp_t        slave_resp_i,
  output logic [CNT_W-1:0] outstanding_o
);

  logic            fifo_full, fifo_empty;
  periph_mst_idx_t fifo_head;
  logic            win_valid;
  periph_mst_idx_t win_idx;
  logic            handshake;
  logic            rsp_pop;

`ifndef PERIPH_ARB_FIXED_PRIO_EN
  periph_mst_idx_t rr_q, rr_d;
`endif

  // Winner selection; a full FIFO masks every request.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef PERIPH_ARB_FIXED_PRIO_EN
    for (int c = 0; c < NUM_MASTERS; c++) begin
      if (!win_valid && master_req_i[c].req) begin
        win_valid = 1'b1;
        win_idx   = periph_mst_idx_t'(c);
      end
    end
`else
    // First pass covers rr_q..N-1, second pass wraps over 0..rr_q-1.
    for (int c = 0; c < NUM_MASTERS; c++) begin
      if (!win_valid && master_req_i[c].req && (c >= int'(rr_q))) begin
        win_valid = 1'b1;
        win_idx   = periph_mst_idx_t'(c);
      end
    end
    for (int c = 0; c < NUM_MASTERS; c++) begin
      if (!win_valid && master_req_i[c].req && (c < int'(rr_q))) begin
        win_valid = 1'b1;
        win_idx   = periph_mst_idx_t'(c);
      end
    end
`endif
    if (fifo_full) begin
      win_valid = 1'b0;
      win_idx   = '0;
    end
  end

  assign handshake = win_valid & slave_resp_i.gnt;
  assign rsp_pop   = slave_resp_i.rvalid & ~fifo_empty;

  // Forward the winner's request; idle bus is all-zero.
  always_comb begin
    slave_req_o = '0;
    for (int c = 0; c < NUM_MASTERS; c++) begin
      if (win_valid && (win_idx == periph_mst_idx_t'(c))) slave_req_o = master_req_i[c];
    end
  end

  // Steer gnt to the winner and rvalid to the FIFO head; rdata is broadcast.
  always_comb begin
    for (int c = 0; c < NUM_MASTERS; c++) begin
      master_resp_o[c].rdata  = slave_resp_i.rdata;
      master_resp_o[c].gnt    = rst_ni & handshake & (win_idx == periph_mst_idx_t'(c));
      master_resp_o[c].rvalid = rst_ni & rsp_pop & (fifo_head == periph_mst_idx_t'(c));
    end
  end

`ifndef PERIPH_ARB_FIXED_PRIO_EN
  // Pointer moves just past the master that completed a handshake.
  always_comb begin
    rr_d = rr_q;
    if (handshake) begin
      rr_d = (win_idx == periph_mst_idx_t'(NUM_MASTERS-1)) ? '0 : win_idx + periph_mst_idx_t'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

  periph_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (win_idx),
    .pop_i   (rsp_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule

// File: doc/periph_obi_arbiter.md
PERIPH_OBI_ARBITER -- requirements
Module: periph_obi_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of OBI masters sharing the peripheral-system slave port (range 2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: maximum number of granted transactions awaiting rvalid (range 1..8).
REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port master_req_i, input, obi_req_t[NUM_MASTERS]: per-master request (req, addr, we, be, wdata).
REQ-006 SHALL have port master_resp_o, output, obi_resp_t[NUM_MASTERS]: per-master gnt, rvalid, rdata.
REQ-007 SHALL have port slave_req_o, output, obi_req_t: request to the peripheral-system slave port.
REQ-008 SHALL have port slave_resp_i, input, obi_resp_t: response from the peripheral-system slave port.
REQ-009 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1): count of transactions granted but not yet answered.

Function
REQ-010 SHALL select one winner per cycle combinationally among masters with req=1, excluding all masters when the ID FIFO is full.
REQ-011 SHALL drive slave_req_o as the winner's request; with no winner, slave_req_o is all-zero.
REQ-012 SHALL set master_resp_o[w].gnt = slave_resp_i.gnt for winner w only; gnt=0 for all other masters.
REQ-013 SHALL, on handshake (slave_req_o.req & slave_resp_i.gnt), push the winner index into the in-order ID FIFO with depth MAX_OUTSTANDING.
REQ-014 SHALL, on slave_resp_i.rvalid with a non-empty FIFO, assert rvalid to the master at the FIFO head and pop it in the same cycle.
REQ-015 SHALL broadcast slave_resp_i.rdata to every master_resp_o[i].rdata; only rvalid is steered.
REQ-016 SHALL ignore rvalid when the FIFO is empty (no master sees rvalid, no state change).
REQ-017 SHALL allow push and pop in the same cycle when not full, with the count unchanged.
REQ-018 SHALL block all grants while full, even if a pop occurs in the same cycle; the request is granted no earlier than the next cycle.
REQ-019 SHALL add zero cycles of arbiter latency on the request path and zero on the response path.
REQ-020 SHALL keep round-robin pointer rr_q; priority search starts at rr_q and wraps modulo NUM_MASTERS; after a handshake by w, rr_q <= (w+1) mod NUM_MASTERS; with no handshake, rr_q holds.
REQ-021 SHALL drive outstanding_o equal to FIFO occupancy.

Reset
REQ-022 SHALL, on rst_ni=0 (including mid-transaction), clear the FIFO, set rr_q=0 and outstanding_o=0; all master gnt/rvalid = 0; slave_req_o follows inputs combinationally.
REQ-023 SHALL drop responses to transactions in flight at reset; they SHALL NOT be delivered after reset release.

Configuration
REQ-024 SHALL, when macro PERIPH_ARB_FIXED_PRIO_EN is defined, use fixed priority (lowest index wins) and remove rr_q.
REQ-025 SHALL, when PERIPH_ARB_FIXED_PRIO_EN is undefined, use the round-robin behaviour of REQ-020.

Structure
REQ-026 SHALL place constant NUM_PERIPH_MASTERS and the index typedef periph_mst_idx_t in cei_mochila_pkg; obi_req_t/obi_resp_t come from obi_pkg.
REQ-027 SHALL implement the ID FIFO as sub-module periph_arb_id_fifo (push, pop, data, full, empty, count).

Verification
REQ-028 SHALL cover: M0 and M1 both req, slave gnt=1 every cycle, round-robin build -> grants alternate M0,M1,M0,M1; rr_q=0,1,0,1 after reset.
REQ-029 SHALL cover: MAX_OUTSTANDING=2, M0 issues 3 reads, rvalid withheld -> 2 grants, 3rd held with gnt=0 and outstanding_o=2; rvalid at cycle t -> 3rd granted at t+1.
REQ-030 SHALL cover: M0 read granted, then M1 read granted, rvalid with rdata 32'h1111_1111 then 32'h2222_2222 -> M0 rvalid on the first, M1 rvalid on the second, never swapped.
REQ-031 SHALL cover: rvalid asserted with outstanding_o=0 -> no master rvalid, outstanding_o stays 0.
REQ-032 SHALL cover: rst_ni low for 1 cycle with outstanding_o=2, then stray rvalid -> no master rvalid, outstanding_o=0, rr_q=0.
REQ-033 SHALL cover: PERIPH_ARB_FIXED_PRIO_EN defined, M0 and M1 req continuously -> M0 granted every cycle, M1 never granted.
